// File: rtl/wordle_guess_scorer.sv
// -----------------------------------------------------------------------------
// wordle_guess_scorer
//
// Scores one Wordle guess against a target word over 2*N_LETTERS clock edges.
// A green pass marks exact-position matches and consumes those target letters.
// A yellow pass then gives each non-green guess letter the lowest-index unused
// matching target letter. Duplicate letters are therefore scored the way the
// game scores them.
//
// Ports
//   Clk        : system clock, all state changes on the rising edge
//   reset      : synchronous, active-high; aborts any score in progress
//   Start      : one-cycle request to score; honoured only when idle
//   Ack        : result acknowledge; honoured only when the result is shown
//   guessWord  : guess, letter 0 in the most significant LETTER_W bits
//   randomWord : target word, same packing as guessWord
//   busy       : high while scoring (see note on r_busy timing)
//   done       : high while a result is presented
//   colors     : 2 bits per letter, letter 0 in the MSB pair
//                00 gray, 01 yellow, 10 green
//   win        : every letter green in the last completed score
// -----------------------------------------------------------------------------
module wordle_guess_scorer #(
    parameter int N_LETTERS = 5,
    parameter int LETTER_W  = 8
) (
    input  logic                            Clk,
    input  logic                            reset,
    input  logic                            Start,
    input  logic                            Ack,
    input  logic [N_LETTERS*LETTER_W-1:0]   guessWord,
    input  logic [N_LETTERS*LETTER_W-1:0]   randomWord,
    output logic                            busy,
    output logic                            done,
    output logic [2*N_LETTERS-1:0]          colors,
    output logic                            win
);

    localparam int WORD_W = N_LETTERS * LETTER_W;
    localparam int IDX_W  = (N_LETTERS > 1) ? $clog2(N_LETTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LETTERS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [1:0] C_YELLOW = 2'b01;
    localparam logic [1:0] C_GREEN  = 2'b10;
    localparam logic [2*N_LETTERS-1:0] ALL_GREEN = {N_LETTERS{C_GREEN}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state, w_state_next;
    logic [IDX_W-1:0]       r_idx, w_idx_next;
    logic [WORD_W-1:0]      r_guess, r_target;
    logic [N_LETTERS-1:0]   r_used, w_used_next;
    logic [2*N_LETTERS-1:0] r_work, w_work_next;
    logic [2*N_LETTERS-1:0] r_colors;
    logic                   r_win;
    logic                   r_busy, w_busy_next;
    logic                   w_capture;
    logic                   w_finish;
    logic                   w_found;
    logic [LETTER_W-1:0]    w_guess_letter;
    logic [LETTER_W-1:0]    w_target_letter;
    logic [1:0]             w_cur_color;
    int                     w_pair_lsb;

    // Letter i of a packed word; letter 0 lives in the top LETTER_W bits.
    function automatic logic [LETTER_W-1:0] letter_at(
        input logic [WORD_W-1:0] word,
        input int                i
    );
        return word[(N_LETTERS - 1 - i) * LETTER_W +: LETTER_W];
    endfunction

    assign w_pair_lsb      = (N_LETTERS - 1 - int'(r_idx)) * 2;
    assign w_guess_letter  = letter_at(r_guess, int'(r_idx));
    assign w_target_letter = letter_at(r_target, int'(r_idx));
    assign w_cur_color     = r_work[w_pair_lsb +: 2];

    // Next-state and working-register updates.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_used_next  = r_used;
        w_work_next  = r_work;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        w_busy_next  = 1'b0;
        w_found      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Ack is irrelevant here, so Start+Ack together simply starts.
                if (Start) begin
                    w_state_next = S_GREEN;
                    w_idx_next   = '0;
                    w_used_next  = '0;
                    w_work_next  = '0;
                    w_capture    = 1'b1;
                end
            end

            S_GREEN: begin
                w_busy_next = 1'b1;
                if (w_guess_letter == w_target_letter) begin
                    w_work_next[w_pair_lsb +: 2] = C_GREEN;
                    w_used_next[r_idx]           = 1'b1;
                end
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_YELLOW;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + IDX_ONE;
                end
            end

            S_YELLOW: begin
                if (w_cur_color != C_GREEN) begin
                    // Lowest-index target letter not yet claimed by a green
                    // or an earlier yellow.
                    for (int j = 0; j < N_LETTERS; j++) begin
                        if (!w_found && !r_used[j] &&
                            (letter_at(r_target, j) == w_guess_letter)) begin
                            w_found        = 1'b1;
                            w_used_next[j] = 1'b1;
                        end
                    end
                    if (w_found) begin
                        w_work_next[w_pair_lsb +: 2] = C_YELLOW;
                    end
                end
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                    w_idx_next   = '0;
                    w_finish     = 1'b1;
                end else begin
                    w_idx_next  = r_idx + IDX_ONE;
                    w_busy_next = 1'b1;
                end
            end

            S_DONE: begin
                // Ack wins over a simultaneous Start; that Start is dropped.
                if (Ack) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // r_busy is registered from the state being left, so it rises one edge
    // after the capture edge and falls on the edge that enters DONE.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_used   <= '0;
            r_work   <= '0;
            r_guess  <= '0;
            r_target <= '0;
            r_colors <= '0;
            r_win    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_used  <= w_used_next;
            r_work  <= w_work_next;
            r_busy  <= w_busy_next;
            if (w_capture) begin
                r_guess  <= guessWord;
                r_target <= randomWord;
            end
            if (w_finish) begin
                r_colors <= w_work_next;
                r_win    <= (w_work_next == ALL_GREEN);
            end
        end
    end

    assign busy   = r_busy;
    assign done   = (r_state == S_DONE);
    assign colors = r_colors;
    assign win    = r_win;

endmodule
